// File: rtl/rs232_pkg.sv
// rs232_pkg: definitions shared by the RS-232 transmitter blocks.
//   tx_state_t    : frame state machine encoding (IDLE, START, DATA, PARITY, STOP)
//   TX_IDLE_LEVEL : level of the TxD line between frames (mark)
//   clog2()       : ceiling log2, used for pointer, level and counter widths
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs232_fifo.sv
// rs232_fifo: synchronous FIFO that queues characters for the transmitter.
// Ports:
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   push     : write din when not full (ignored while full)
//   pop      : advance the read pointer when not empty (ignored while empty)
//   din      : write data
//   dout     : head of the FIFO (valid while empty=0)
//   full     : DEPTH entries stored
//   empty    : no entries stored
//   level    : number of stored entries, 0..DEPTH
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rs232_fifo
  import rs232_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DW-1:0]         din,
  output logic [DW-1:0]         dout,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level   = wptr - rptr;
  assign dout    = mem[rptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: RS-232 transmitter with programmable bit time, character
// width, one or two stop bits and a small write FIFO.
// Ports:
//   clk, rst : clock, synchronous active-high reset (aborts any frame)
//   wr, data : enqueue a character when rdy=1; writes while rdy=0 are dropped
//   div      : clocks per bit (>=2), latched at the start of each frame
//   stop2    : 0 = one stop bit, 1 = two stop bits, latched per frame
//   pen,podd : parity enable / odd parity, latched per frame (parity build only)
//   rdy      : FIFO not full
//   busy     : frame in progress or characters queued
//   level    : FIFO occupancy
//   TxD      : serial line, idle high
// Build option: define RS232_TX_PARITY_EN to add an optional parity bit
// between the data bits and the stop bit(s). Without it pen/podd are ignored.
//
// Handshake: a character is accepted on a rising edge where wr=1 and rdy=1;
// rdy depends only on registered FIFO state, so a pop in the same cycle never
// makes room for a write to a full FIFO.
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int DIVW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DW-1:0]         data,
  input  logic [DIVW-1:0]       div,
  input  logic                  stop2,
  input  logic                  pen,
  input  logic                  podd,
  output logic                  rdy,
  output logic                  busy,
  output logic [clog2(DEPTH):0] level,
  output logic                  TxD
);

  localparam int BW = clog2(DW);

  tx_state_t       state;
  tx_state_t       after_data;
  logic [DIVW-1:0] tick;
  logic [DIVW-1:0] div_q;
  logic [BW-1:0]   bitcnt;
  logic            stopcnt;
  logic            stop2_q;
  logic [DW-1:0]   shreg;
  logic [DW-1:0]   head;
  logic            full;
  logic            empty;
  logic            endtick;
  logic            last_stop;
  logic            load;

  rs232_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .pop   (load),
    .din   (data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign rdy       = ~full;
  assign busy      = (state != IDLE) | ~empty;
  assign endtick   = (tick == div_q - 1'b1);
  assign last_stop = ~stop2_q | stopcnt;

  // A frame starts (and the FIFO is popped) either from IDLE or directly at
  // the end of the last stop bit, which gives back-to-back frames.
  assign load = ~empty & ((state == IDLE) | ((state == STOP) & endtick & last_stop));

`ifdef RS232_TX_PARITY_EN
  logic pen_q;
  logic par_q;
  assign after_data = pen_q ? PARITY : STOP;
`else
  logic unused_par;
  assign unused_par = pen ^ podd;
  assign after_data = STOP;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tick    <= '0;
      div_q   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      stop2_q <= 1'b0;
      shreg   <= '0;
`ifdef RS232_TX_PARITY_EN
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      if (state != IDLE) tick <= endtick ? '0 : tick + 1'b1;

      case (state)
        START: if (endtick) state <= DATA;
        DATA: begin
          if (endtick) begin
            shreg <= shreg >> 1;
            if (bitcnt == BW'(DW - 1)) begin
              bitcnt <= '0;
              state  <= after_data;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        PARITY: if (endtick) state <= STOP;
        STOP: begin
          if (endtick) begin
            if (!last_stop) stopcnt <= 1'b1;
            else            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Frame configuration is captured here so later changes to div/stop2
      // only affect the next character.
      if (load) begin
        state   <= START;
        tick    <= '0;
        bitcnt  <= '0;
        stopcnt <= 1'b0;
        shreg   <= head;
        div_q   <= div;
        stop2_q <= stop2;
`ifdef RS232_TX_PARITY_EN
        pen_q   <= pen;
        par_q   <= (^head) ^ podd;
`endif
      end
    end
  end

  always_comb begin
    TxD = TX_IDLE_LEVEL;
    case (state)
      START:  TxD = 1'b0;
      DATA:   TxD = shreg[0];
`ifdef RS232_TX_PARITY_EN
      PARITY: TxD = par_q;
`endif
      default: TxD = TX_IDLE_LEVEL;
    endcase
  end

endmodule
